// File: rtl/alu_ex_stage_if.sv
// Execute-stage bus: upstream operation handshake plus the downstream result handshake.
interface alu_ex_stage_if #(
    parameter int unsigned RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_a;
    logic [31:0]     in_b;
    logic [3:0]      in_op;
    logic [RD_W-1:0] in_rd;
    logic [1:0]      in_br;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic            out_zero;
    logic            out_cout;
    logic [RD_W-1:0] out_rd;
    logic            out_taken;
    logic            out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_op, in_rd, in_br, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_cout, out_rd, out_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_rd, in_br, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_cout, out_rd, out_taken, out_illegal
    );
endinterface

// File: rtl/alu_ex_stage.sv
// Two-stage execute pipeline around a 32-bit ALU: S1 holds operands, S2 holds results.
// Both stages use valid/ready with full throughput, backpressure, flush and a retire counter.
module alu32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result_c,
    output logic        zero_c,
    output logic        cout_c
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    logic [32:0] sum_c;

    // Cout is only meaningful for ADD/SUB; SUB carry is 1 when no borrow occurs.
    always_comb begin
        result_c = 32'd0;
        cout_c   = 1'b0;
        sum_c    = 33'd0;
        case (op)
            OP_AND: result_c = a & b;
            OP_OR:  result_c = a | b;
            OP_ADD: begin
                sum_c    = 33'(a) + 33'(b);
                result_c = sum_c[31:0];
                cout_c   = sum_c[32];
            end
            OP_SUB: begin
                sum_c    = 33'(a) + 33'(~b) + 33'd1;
                result_c = sum_c[31:0];
                cout_c   = sum_c[32];
            end
            OP_SLT: result_c = 32'($signed(a) < $signed(b));
            OP_SLL: result_c = a << b[4:0];
            OP_SRL: result_c = a >> b[4:0];
            OP_SRA: result_c = 32'($signed(a) >>> b[4:0]);
            default: result_c = 32'd0;
        endcase
    end

    assign zero_c = (result_c == 32'd0);
endmodule

module alu_ex_stage #(
    parameter int unsigned RD_W  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    alu_ex_stage_if.slave        bus,
    output logic [CNT_W-1:0]     retired
);
    logic            s1_valid;
    logic [31:0]     s1_a;
    logic [31:0]     s1_b;
    logic [3:0]      s1_op;
    logic [RD_W-1:0] s1_rd;
    logic [1:0]      s1_br;

    logic            s2_valid;
    logic [31:0]     s2_result;
    logic            s2_zero;
    logic            s2_cout;
    logic [RD_W-1:0] s2_rd;
    logic            s2_taken;
    logic            s2_illegal;

    logic            s2_adv_c;
    logic            s1_adv_c;
    logic            in_fire_c;
    logic            out_fire_c;
    logic [31:0]     alu_result_c;
    logic            alu_zero_c;
    logic            alu_cout_c;
    logic            taken_c;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1000, 4'b1001, 4'b1010: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    assign s2_adv_c   = !s2_valid || bus.out_ready;
    assign s1_adv_c   = !s1_valid || s2_adv_c;
    assign in_fire_c  = bus.in_valid && bus.in_ready;
    assign out_fire_c = s2_valid && bus.out_ready;

    // Flush blocks acceptance so a same-cycle offer is neither taken nor lost silently.
    assign bus.in_ready = s1_adv_c && !flush;

    alu32 u_alu (
        .a        (s1_a),
        .b        (s1_b),
        .op       (s1_op),
        .result_c (alu_result_c),
        .zero_c   (alu_zero_c),
        .cout_c   (alu_cout_c)
    );

    assign taken_c = ((s1_br == 2'b01) && alu_zero_c) || ((s1_br == 2'b10) && !alu_zero_c);

    // S1 operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= 32'd0;
            s1_b     <= 32'd0;
            s1_op    <= 4'd0;
            s1_rd    <= '0;
            s1_br    <= 2'd0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire_c) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_op    <= bus.in_op;
            s1_rd    <= bus.in_rd;
            s1_br    <= bus.in_br;
        end else if (s1_adv_c) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_result  <= 32'd0;
            s2_zero    <= 1'b0;
            s2_cout    <= 1'b0;
            s2_rd      <= '0;
            s2_taken   <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_valid && s2_adv_c) begin
            s2_valid   <= 1'b1;
            s2_result  <= alu_result_c;
            s2_zero    <= alu_zero_c;
            s2_cout    <= alu_cout_c;
            s2_rd      <= s1_rd;
            s2_taken   <= taken_c;
            s2_illegal <= !op_legal(s1_op);
        end else if (s2_adv_c) begin
            s2_valid <= 1'b0;
        end
    end

    // A handshake completing in a flush cycle still retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (out_fire_c) begin
            retired <= retired + CNT_W'(1);
        end
    end

    assign bus.out_valid   = s2_valid;
    assign bus.out_result  = s2_result;
    assign bus.out_zero    = s2_zero;
    assign bus.out_cout    = s2_cout;
    assign bus.out_rd      = s2_rd;
    assign bus.out_taken   = s2_taken;
    assign bus.out_illegal = s2_illegal;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed self-checking bench for alu_ex_stage; uses a 4-bit retire counter so wrap is reachable.
module tb_alu_ex_stage;
    localparam int unsigned RD_W = 5;
    localparam int unsigned CW   = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] retired;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;

    logic [31:0]     va [16];
    logic [31:0]     vb [16];
    logic [3:0]      vop[16];
    logic [RD_W-1:0] vrd[16];
    logic [1:0]      vbr[16];
    logic [31:0]     er [16];
    logic            ez [16];
    logic            et [16];

    alu_ex_stage_if #(.RD_W(RD_W)) bus ();

    alu_ex_stage #(.RD_W(RD_W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus.slave),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_stream(input int n, input string name);
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                bus.in_valid = 1'b1;
                bus.in_a  = va[c];
                bus.in_b  = vb[c];
                bus.in_op = vop[c];
                bus.in_rd = vrd[c];
                bus.in_br = vbr[c];
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_in_ready[%0d]: got %b exp 1", name, c, bus.in_ready);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (c == 0) begin
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_latency: out_valid got %b exp 0 one cycle after accept", name, bus.out_valid);
                end
            end else if (bus.out_valid !== 1'b1 || bus.out_result !== er[c-1] || bus.out_zero !== ez[c-1] ||
                         bus.out_rd !== vrd[c-1] || bus.out_taken !== et[c-1] || bus.out_illegal !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d]: got v=%b r=%h z=%b rd=%0d t=%b il=%b exp v=1 r=%h z=%b rd=%0d t=%b il=0",
                         name, c-1, bus.out_valid, bus.out_result, bus.out_zero, bus.out_rd, bus.out_taken,
                         bus.out_illegal, er[c-1], ez[c-1], vrd[c-1], et[c-1]);
            end
        end
        exp_ret += n;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || retired !== CW'(exp_ret)) begin
            errors++;
            $display("FAIL %s_drain: got v=%b retired=%0d exp v=0 retired=%0d", name, bus.out_valid, retired, CW'(exp_ret));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_rd = '0; bus.in_br = '0;
        bus.out_ready = 1'b1;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || retired !== '0 || bus.out_result !== '0 || bus.out_rd !== '0 ||
            bus.out_taken !== 1'b0 || bus.out_illegal !== 1'b0 || bus.out_zero !== 1'b0 || bus.out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ret=%0d r=%h rd=%0d t=%b il=%b z=%b c=%b exp all 0",
                     bus.out_valid, retired, bus.out_result, bus.out_rd, bus.out_taken, bus.out_illegal,
                     bus.out_zero, bus.out_cout);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        va[0] = 32'h5; vb[0] = 32'h3; vop[0] = 4'b0010; vrd[0] = 5'd7; vbr[0] = 2'b00;
        er[0] = 32'h8; ez[0] = 1'b0; et[0] = 1'b0;
        run_stream(1, "add");
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            va[i] = 32'h10; vb[i] = 32'h10; vop[i] = 4'b0110; vrd[i] = 5'(i + 1);
            er[i] = 32'h0; ez[i] = 1'b1;
        end
        vbr[0] = 2'b01; et[0] = 1'b1;
        vbr[1] = 2'b10; et[1] = 1'b0;
        vbr[2] = 2'b11; et[2] = 1'b0;
        run_stream(3, "branch");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            va[k] = 32'h1; vb[k] = 32'(k); vop[k] = 4'b1000; vrd[k] = 5'(k); vbr[k] = 2'b00;
            et[k] = 1'b0; ez[k] = 1'b0;
        end
        er[0] = 32'h01; er[1] = 32'h02; er[2] = 32'h04; er[3] = 32'h08;
        er[4] = 32'h10; er[5] = 32'h20; er[6] = 32'h40; er[7] = 32'h80;
        run_stream(8, "stream_sll");
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int recv = 0;
        logic saw_low = 1'b0;
        logic held_prev = 1'b0;
        logic [31:0] snap_r = '0;
        logic [RD_W-1:0] snap_rd = '0;
        logic fire_in;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            bus.out_ready = !(cyc >= 2 && cyc <= 6);
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_a = 32'(100 + sent); bus.in_b = 32'h1; bus.in_op = 4'b0010;
                bus.in_rd = 5'(sent); bus.in_br = 2'b00;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (held_prev) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== snap_r || bus.out_rd !== snap_rd) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: got v=%b r=%h rd=%0d exp v=1 r=%h rd=%0d",
                             cyc, bus.out_valid, bus.out_result, bus.out_rd, snap_r, snap_rd);
                end
            end
            if (!bus.in_ready) saw_low = 1'b1;
            fire_in = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_result !== 32'(101 + recv) || bus.out_rd !== 5'(recv)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got r=%h rd=%0d exp r=%h rd=%0d",
                             recv, bus.out_result, bus.out_rd, 32'(101 + recv), 5'(recv));
                end
                recv++;
            end
            held_prev = bus.out_valid && !bus.out_ready;
            snap_r  = bus.out_result;
            snap_rd = bus.out_rd;
            if (fire_in) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        exp_ret += 8;
        checks++;
        if (recv != 8 || sent != 8 || saw_low !== 1'b1 || bus.out_valid !== 1'b0 || retired !== CW'(exp_ret)) begin
            errors++;
            $display("FAIL bp_summary: got recv=%0d sent=%0d in_ready_dropped=%b v=%b retired=%0d exp 8 8 1 0 %0d",
                     recv, sent, saw_low, bus.out_valid, retired, CW'(exp_ret));
        end
    endtask

    task automatic test_flush_illegal();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'h1; bus.in_b = 32'h1; bus.in_op = 4'b0010; bus.in_rd = 5'd1; bus.in_br = 2'b00;
        @(posedge clk); #1;
        bus.in_a = 32'h2; bus.in_rd = 5'd2;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h2 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill: got v=%b r=%h in_ready=%b exp v=1 r=00000002 in_ready=0",
                     bus.out_valid, bus.out_result, bus.in_ready);
        end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_a = 32'h3; bus.in_rd = 5'd3;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b exp 0", bus.in_ready);
        end
        exp_ret += 1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || retired !== CW'(exp_ret)) begin
            errors++;
            $display("FAIL flush_kill: got v=%b retired=%0d exp v=0 retired=%0d", bus.out_valid, retired, CW'(exp_ret));
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: out_valid got %b exp 0", bus.out_valid);
        end
        bus.in_valid = 1'b1; bus.in_a = 32'h3; bus.in_b = 32'h4; bus.in_op = 4'b1111; bus.in_rd = 5'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_rd !== 5'd9) begin
            errors++;
            $display("FAIL illegal_op: got v=%b il=%b rd=%0d exp v=1 il=1 rd=9", bus.out_valid, bus.out_illegal, bus.out_rd);
        end
        exp_ret += 1;
        @(posedge clk); #1;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1; vop[0] = 4'b0010; vrd[0] = 5'd4; vbr[0] = 2'b00;
        er[0] = 32'h0; ez[0] = 1'b1; et[0] = 1'b0;
        run_stream(1, "post_flush_add");
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'h7; bus.in_b = 32'h1; bus.in_op = 4'b0001; bus.in_rd = 5'd5; bus.in_br = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || retired !== CW'(exp_ret) || retired === '0) begin
            errors++;
            $display("FAIL pre_reset: got v=%b retired=%0d exp v=1 retired=%0d (nonzero)", bus.out_valid, retired, CW'(exp_ret));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || retired !== '0 || bus.out_result !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b retired=%0d r=%h exp 0 0 0", bus.out_valid, retired, bus.out_result);
        end
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        exp_ret = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++) begin
            va[i] = 32'(i); vb[i] = 32'(i); vop[i] = 4'b0010; vrd[i] = 5'(i); vbr[i] = 2'b00;
            er[i] = 32'(2 * i); ez[i] = (i == 0); et[i] = 1'b0;
        end
        run_stream(15, "wrap_fill");
        va[0] = 32'h8000_0000; vb[0] = 32'h1; vop[0] = 4'b1010; vrd[0] = 5'd31; vbr[0] = 2'b00;
        er[0] = 32'hC000_0000; ez[0] = 1'b0; et[0] = 1'b0;
        run_stream(1, "wrap_sra");
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_back_to_back();
        test_backpressure();
        test_flush_illegal();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
